// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage. Issues one imem read at a time and
//            drives the IF/ID register. Optional macro IF_EBREAK_HALT_EN
//            adds a HALT state entered when ebreak is loaded into IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flash,
  input  logic [31:0] target_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
);

  localparam logic [1:0] C_ST_REQ  = 2'd0;
  localparam logic [1:0] C_ST_WAIT = 2'd1;
  localparam logic [1:0] C_ST_DROP = 2'd2;
`ifdef IF_EBREAK_HALT_EN
  localparam logic [1:0] C_ST_HALT = 2'd3;
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inflight_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_inst;
  logic [31:0] r_pend_pc;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic        r_valid;

  logic        w_req_fire;
  logic        w_resp_take;
  logic        w_ifid_load;
  logic [31:0] w_load_inst;
  logic [31:0] w_load_pc;
  logic        w_unused_target_lsb;

  assign w_unused_target_lsb = ^target_pc[1:0];

  // The reset term keeps the request low while rst is asserted.
  assign imem_req_valid = rst & (r_state == C_ST_REQ) & ~r_pend_valid & ~flash;
  assign imem_addr      = r_fetch_pc;

  assign w_req_fire  = imem_req_valid & imem_req_ready;
  assign w_resp_take = (r_state == C_ST_WAIT) & imem_resp_valid & ~flash;
  assign w_ifid_load = ~flash & ~stall & (r_pend_valid | w_resp_take);
  assign w_load_inst = r_pend_valid ? r_pend_inst : imem_resp_data;
  assign w_load_pc   = r_pend_valid ? r_pend_pc   : r_inflight_pc;

`ifdef IF_EBREAK_HALT_EN
  logic w_halt_hit;
  assign w_halt_hit = w_ifid_load & (w_load_inst[6:0] == 7'b1110011) &
                      (w_load_inst[31:20] == 12'h001);
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (flash) begin
      // A response still owed to a killed request must be swallowed in DROP.
      if (((r_state == C_ST_WAIT) || (r_state == C_ST_DROP)) && !imem_resp_valid)
        w_state_nxt = C_ST_DROP;
      else
        w_state_nxt = C_ST_REQ;
    end else begin
      case (r_state)
        C_ST_REQ:  if (w_req_fire)      w_state_nxt = C_ST_WAIT;
        C_ST_WAIT: if (imem_resp_valid) w_state_nxt = C_ST_REQ;
        C_ST_DROP: if (imem_resp_valid) w_state_nxt = C_ST_REQ;
        default:   w_state_nxt = r_state;
      endcase
`ifdef IF_EBREAK_HALT_EN
      if (w_halt_hit) w_state_nxt = C_ST_HALT;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= C_ST_REQ;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_inst   <= NOP_INST;
      r_pend_pc     <= 32'd0;
      r_ir          <= NOP_INST;
      r_pc          <= 32'd0;
      r_npc         <= 32'd4;
      r_valid       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (flash) begin
        r_fetch_pc   <= {target_pc[31:2], 2'b00};
        r_pend_valid <= 1'b0;
      end else begin
        if (w_req_fire)
          r_inflight_pc <= r_fetch_pc;
        if (w_resp_take)
          r_fetch_pc <= r_inflight_pc + 32'd4;
        if (w_ifid_load && r_pend_valid) begin
          r_pend_valid <= 1'b0;
        end else if (w_resp_take && (stall || r_pend_valid)) begin
          r_pend_valid <= 1'b1;
          r_pend_inst  <= imem_resp_data;
          r_pend_pc    <= r_inflight_pc;
        end
      end

      // Bubbles keep PC/NPC so decode still sees the last fetched address.
      if (flash || (!stall && !w_ifid_load)) begin
        r_ir    <= NOP_INST;
        r_valid <= 1'b0;
      end else if (w_ifid_load) begin
        r_ir    <= w_load_inst;
        r_pc    <= w_load_pc;
        r_npc   <= w_load_pc + 32'd4;
        r_valid <= 1'b1;
      end
    end
  end

  assign if_id_IR         = r_ir;
  assign if_id_PC         = r_pc;
  assign if_id_NPC        = r_npc;
  assign if_id_valid_inst = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage: directed vector table,
//            randomized traffic against a queue-based fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NV  = 27;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flash = 1'b0;
  logic [31:0] target_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_NPC;
  logic        if_id_valid_inst;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flash            (flash),
    .target_pc        (target_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_NPC        (if_id_NPC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  typedef struct {
    logic        stall;
    logic        flash;
    logic [31:0] target;
    logic        ready;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_valid;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic s, input logic f, input logic [31:0] t,
                              input logic r, input logic v, input logic [31:0] d,
                              input logic er, input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep, input logic [31:0] en, input logic ev);
    vec_t x;
    x.stall = s;  x.flash = f;  x.target = t; x.ready = r; x.rv = v; x.rd = d;
    x.e_req = er; x.e_addr = ea; x.e_ir = ei; x.e_pc = ep; x.e_npc = en; x.e_valid = ev;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] t,
                       input logic r, input logic v, input logic [31:0] d);
    @(negedge clk);
    stall = s; flash = f; target_pc = t;
    imem_req_ready = r; imem_resp_valid = v; imem_resp_data = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0; stall = 1'b0; flash = 1'b0; target_pc = 32'd0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_ir", if_id_IR, NOP);
    chk("rst_pc", if_id_PC, 32'd0);
    chk("rst_npc", if_id_NPC, 32'd4);
    chk("rst_valid", if_id_valid_inst, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] d;
    d = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    if (d[6:0] == 7'b1110011) d[0] = 1'b0;
    return d;
  endfunction

  task automatic random_phase();
    logic        outst = 1'b0;
    logic        killed = 1'b0;
    logic        prev_unacc = 1'b0;
    logic        acc;
    int          cnt = 0;
    int          delivered = 0;
    logic [31:0] out_addr = 32'd0;
    logic [31:0] next_req = 32'd0;
    logic [31:0] prev_addr = 32'd0;
    logic [63:0] q [$];
    logic [31:0] e_ir = NOP;
    logic [31:0] e_pc = 32'd0;
    logic [31:0] e_npc = 32'd4;
    logic        e_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      flash          = ($urandom_range(0, 11) == 0);
      target_pc      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      stall          = ($urandom_range(0, 2) == 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (outst && cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(out_addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
      #1;
      if (imem_req_valid) chk("one_outstanding", outst, 1'b0);
      if (flash) chk("flash_req_low", imem_req_valid, 1'b0);
      if (prev_unacc && !flash) begin
        chk("req_held", imem_req_valid, 1'b1);
        chk("addr_held", imem_addr, prev_addr);
      end
      acc = imem_req_valid & imem_req_ready;
      if (acc) chk("req_addr", imem_addr, next_req);
      prev_unacc = imem_req_valid & ~imem_req_ready;
      prev_addr  = imem_addr;

      // Fetch model: a redirect kills any in-flight read and everything queued.
      if (flash && outst) killed = 1'b1;
      if (imem_resp_valid) begin
        if (!killed) q.push_back({out_addr, imem_resp_data});
        outst = 1'b0;
      end else if (outst) begin
        cnt--;
      end
      if (acc) begin
        outst    = 1'b1;
        killed   = 1'b0;
        out_addr = next_req;
        cnt      = $urandom_range(0, 2);
        next_req = next_req + 32'd4;
      end
      if (flash) begin
        q.delete();
        next_req = {target_pc[31:2], 2'b00};
      end
      if (flash || (!stall && q.size() == 0)) begin
        e_ir = NOP; e_valid = 1'b0;
      end else if (!stall) begin
        {e_pc, e_ir} = q.pop_front();
        e_npc   = e_pc + 32'd4;
        e_valid = 1'b1;
        delivered++;
      end

      @(posedge clk);
      #1;
      chk("rnd_ir", if_id_IR, e_ir);
      chk("rnd_pc", if_id_PC, e_pc);
      chk("rnd_npc", if_id_NPC, e_npc);
      chk("rnd_valid", if_id_valid_inst, e_valid);
    end
    chk("delivered_min", (delivered >= 100) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    //              stl flh target        rdy rv data          req addr          ir            pc            npc           vld
    tbl[0]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         NOP,          32'h0,        32'h4,        0);
    tbl[1]  = mk(0, 0, 32'h0,         1, 1, 32'h0050_0093, 0, 32'h0,         NOP,          32'h0,        32'h4,        0);
    tbl[2]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h4,         32'h0050_0093, 32'h0,       32'h4,        1);
    tbl[3]  = mk(0, 0, 32'h0,         1, 1, 32'h00A0_0113, 0, 32'h4,         NOP,          32'h0,        32'h4,        0);
    tbl[4]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         32'h00A0_0113, 32'h4,       32'h8,        1);
    tbl[5]  = mk(1, 0, 32'h0,         1, 1, 32'h0030_8193, 0, 32'h8,         32'h00A0_0113, 32'h4,       32'h8,        1);
    tbl[6]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         0, 32'hC,         32'h00A0_0113, 32'h4,       32'h8,        1);
    tbl[7]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'hC,         32'h00A0_0113, 32'h4,       32'h8,        1);
    tbl[8]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hC,         32'h0030_8193, 32'h8,       32'hC,        1);
    tbl[9]  = mk(0, 1, 32'h100,       1, 0, 32'h0,         0, 32'hC,         NOP,          32'h8,        32'hC,        0);
    tbl[10] = mk(0, 0, 32'h0,         1, 1, 32'hDEAD_BEEF, 0, 32'h100,       NOP,          32'h8,        32'hC,        0);
    tbl[11] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h100,       NOP,          32'h8,        32'hC,        0);
    tbl[12] = mk(0, 1, 32'h200,       0, 0, 32'h0,         0, 32'h100,       NOP,          32'h8,        32'hC,        0);
    tbl[13] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,       NOP,          32'h8,        32'hC,        0);
    tbl[14] = mk(0, 0, 32'h0,         1, 1, 32'h0040_0213, 0, 32'h200,       NOP,          32'h8,        32'hC,        0);
    tbl[15] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h204,       32'h0040_0213, 32'h200,     32'h204,      1);
    tbl[16] = mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,         0, 32'h204,       NOP,          32'h200,      32'h204,      0);
    tbl[17] = mk(0, 0, 32'h0,         1, 1, 32'hCAFE_F00D, 0, 32'hFFFF_FFFC, NOP,          32'h200,      32'h204,      0);
    tbl[18] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, NOP,          32'h200,      32'h204,      0);
    tbl[19] = mk(0, 0, 32'h0,         1, 1, 32'h0010_0093, 0, 32'hFFFF_FFFC, NOP,          32'h200,      32'h204,      0);
    tbl[20] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         32'h0010_0093, 32'hFFFF_FFFC, 32'h0,      1);
    tbl[21] = mk(0, 1, 32'h303,       0, 0, 32'h0,         0, 32'h0,         NOP,          32'hFFFF_FFFC, 32'h0,       0);
    tbl[22] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h300,       NOP,          32'hFFFF_FFFC, 32'h0,       0);
    tbl[23] = mk(0, 1, 32'h400,       1, 1, 32'h1111_1111, 0, 32'h300,       NOP,          32'hFFFF_FFFC, 32'h0,       0);
    tbl[24] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h400,       NOP,          32'hFFFF_FFFC, 32'h0,       0);
    tbl[25] = mk(0, 0, 32'h0,         0, 1, 32'h1234_5678, 0, 32'h400,       NOP,          32'hFFFF_FFFC, 32'h0,       0);
    tbl[26] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h404,       32'h1234_5678, 32'h400,     32'h404,      1);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].stall, tbl[i].flash, tbl[i].target, tbl[i].ready, tbl[i].rv, tbl[i].rd);
      chk($sformatf("v%0d_req_valid", i), imem_req_valid, tbl[i].e_req);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_ir", i), if_id_IR, tbl[i].e_ir);
      chk($sformatf("v%0d_pc", i), if_id_PC, tbl[i].e_pc);
      chk($sformatf("v%0d_npc", i), if_id_NPC, tbl[i].e_npc);
      chk($sformatf("v%0d_valid", i), if_id_valid_inst, tbl[i].e_valid);
    end

    do_reset();
    random_phase();

`ifdef IF_EBREAK_HALT_EN
    do_reset();
    drive(0, 1, 32'h40, 0, 0, 32'h0);
    chk("halt_flash_req", imem_req_valid, 1'b0);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk("halt_req40", imem_req_valid, 1'b1);
    chk("halt_addr40", imem_addr, 32'h40);
    drive(0, 0, 32'h0, 1, 1, 32'h0010_0073);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk("halt_ir", if_id_IR, 32'h0010_0073);
    chk("halt_pc", if_id_PC, 32'h40);
    chk("halt_valid", if_id_valid_inst, 1'b1);
    chk("halt_no_req", imem_req_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 32'h0, 1, 0, 32'h0);
      chk("halt_no_req_k", imem_req_valid, 1'b0);
      chk("halt_bubble_k", if_id_valid_inst, 1'b0);
    end
    drive(0, 1, 32'h80, 1, 0, 32'h0);
    chk("halt_exit_req", imem_req_valid, 1'b0);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk("halt_resume_req", imem_req_valid, 1'b1);
    chk("halt_resume_addr", imem_addr, 32'h80);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
